spi_adc_scanner: RTL
====================

# spi_adc_scanner

Parametrised multi-channel SPI ADC scan controller for the sensor interface subsystem. A rising edge on `go` starts a scan over the enabled channels, with an optional free-running continuous mode. Each channel is converted with one fixed-format SPI frame, and each result is presented on a valid-pulsed output bus. The block sits between the go PIO and the sensor ADC pins, and replaces processor-driven SPI transfers with hardware sequencing.

## Interface
Parameters:
- `NUM_CH`, 8: number of ADC channels, 2..16; `CH_W = max(1, $clog2(NUM_CH))` (localparam).
- `DATA_W`, 12: ADC result width; must satisfy `1 + CH_W + DATA_W <= 16`.
- `CLK_DIV`, 4: clk cycles per SCLK half-period, ≥2.

Ports:
- `clk_clk` in 1: single clock; all logic on its rising edge.
- `reset_reset` in 1: synchronous, active-high reset.
- `go` in 1: level from PIO; its rising edge starts a scan.
- `cont` in 1: continuous mode; sampled at end of each scan.
- `ch_en` in NUM_CH: channel enable mask; latched at scan start.
- `spi_MISO` in 1: ADC data out.
- `spi_MOSI`, `spi_SCLK`, `spi_SS_n` out 1 each: SPI mode 0.
- `res_valid` out 1: one-cycle pulse per converted channel.
- `res_ch` out CH_W: channel of the current result.
- `res_data` out DATA_W: result value.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse at scan completion.

## Operation
- Reset values: SS_n=1, SCLK=0, MOSI=0, res_valid=0, res_ch=0, res_data=0, busy=0, scan_done=0, go-edge register=0, state IDLE.
- Go edge: `go`=1 and registered previous `go`=0. Go edges while busy are ignored.
- Scan order: ascending channel index; disabled channels are skipped with zero cycles spent.
- Frame format: 16 SCLK bits, MSB first.
  - MOSI: bit0 = 1 (start), bits 1..CH_W = channel MSB first, remaining bits 0.
  - MISO: sampled on the last DATA_W rising SCLK edges and shifted in MSB first; earlier MISO bits are ignored.
- FSM states:
  - IDLE → SETUP on go edge with a nonzero mask.
  - SETUP: SS_n low, SCLK low, MOSI = bit0 → HIGH.
  - HIGH: SCLK high; MISO sampled on entry → LOW. After bit 15, goes to HOLD instead.
  - LOW: SCLK low; MOSI shows next bit → HIGH.
  - HOLD: SCLK low, SS_n low → GAP.
  - GAP: SS_n high → SETUP (next enabled channel, or next scan if continuous) or IDLE.
  - Each state lasts CLK_DIV cycles.
- Result: res_valid pulses on the edge SS_n rises, with res_ch/res_data updated on that edge and held until the next result.
- End of scan: scan_done pulses together with the last channel's res_valid. At the end of GAP:
  - If `cont`=1, the mask is re-latched and a new scan starts.
  - Otherwise the FSM goes to IDLE and busy falls.
- Zero mask at go edge: scan_done pulses on the next edge; busy stays 0; no SPI activity; the FSM stays in IDLE even if `cont`=1.
- Zero mask at continuous restart: FSM returns to IDLE and busy falls; no extra scan_done.
- Reset mid-frame: on the reset edge SS_n=1, SCLK=0, and no res_valid or scan_done is issued for the aborted frame.

## Timing
- go edge sampled at edge N: busy=1 and SS_n=0 from edge N+1.
- First SCLK rise at CLK_DIV cycles after SS_n falls.
- SS_n low for 33·CLK_DIV cycles per frame; 132 cycles at CLK_DIV=4.
- Frame-to-frame period: 34·CLK_DIV cycles.
- Scan latency from go edge to scan_done: 1 + (34·k − 1)·CLK_DIV cycles, where k = number of frames in the scan.
- MOSI changes only on the edge where SCLK falls or SS_n falls.

## Configuration
- `SPI_ADC_SCAN_OVERSAMPLE_EN` defined:
  - Each enabled channel is converted in 4 back-to-back frames (k = 4 × enabled channels).
  - Samples accumulate in a DATA_W+2-bit sum.
  - res_data = sum[DATA_W+1:2] (truncating average); one res_valid per channel, issued after the 4th frame.
- Undefined: one frame per channel; no accumulator is instantiated.

## Test plan
- Reset: hold reset_reset 3 cycles mid-frame → next edge SS_n=1, SCLK=0; all other outputs 0; no res_valid afterwards.
- Single scan (NUM_CH=8, CLK_DIV=4, ch_en=8'h05; ADC model returns 12'hA5C for ch0, 12'h3F1 for ch2):
  - MOSI start+channel bits are 1000 then 1010.
  - res_valid pulses with (0, A5C), then (2, 3F1).
  - scan_done coincides with the second res_valid, 1+67·4 = 269 cycles after the go edge.
- Zero mask: ch_en=0 with a go edge → scan_done pulses 1 cycle later; busy=0; SS_n never falls.
- Continuous mode: cont=1, ch_en=8'h80 → frames every 136 cycles. Clearing cont mid-frame completes that scan, then busy falls.
- Go while busy: a second go edge during a frame → no extra frames; result count unchanged.
- Oversample (macro defined, ch_en=8'h02, samples 100, 101, 102, 103) → single res_valid with res_ch=1, res_data=101.

Source files
------------

// File: rtl/spi_adc_scanner.sv
// Hardware scan controller: one 16-bit SPI mode-0 frame per enabled ADC channel, results on a valid-pulsed bus.
// SPI_ADC_SCAN_OVERSAMPLE_EN: four frames per channel, result is the truncated average.
module spi_adc_scanner #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4,
  localparam int CH_W   = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              go,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              spi_MISO,
  output logic              spi_MOSI,
  output logic              spi_SCLK,
  output logic              spi_SS_n,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              scan_done
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DSKIP = 16 - DATA_W;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [3:0]          bit_idx, bit_n;
  logic [NUM_CH-1:0]   mask, mask_n;
  logic [CH_W-1:0]     ch, ch_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                go_q, go_edge;
  logic                ss_n_n, sclk_n, mosi_n, valid_n, done_n, busy_n;
  logic [CH_W-1:0]     res_ch_n;
  logic [DATA_W-1:0]   res_data_n;
  logic                tick, start, sample, more;
  logic [CH_W:0]       first_hit, next_hit;
  logic [15:0]         tx_word;
`ifdef SPI_ADC_SCAN_OVERSAMPLE_EN
  logic [1:0]          os_cnt, os_cnt_n;
  logic [DATA_W+1:0]   acc, acc_n, acc_sum;
  assign acc_sum = acc + {2'b00, shreg};
  assign more    = (os_cnt != 2'd0);
`else
  assign more    = 1'b0;
`endif

  // {found, index} of the lowest set bit of m at or above lo
  function automatic logic [CH_W:0] lowest_from(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
  assign first_hit = lowest_from(ch_en, 0);
  assign next_hit  = lowest_from(mask, int'(ch) + 1);
  assign tx_word   = {1'b1, ch, {(15 - CH_W){1'b0}}};

  always_comb begin
    state_n    = state;
    cnt_n      = (state == IDLE || tick) ? '0 : cnt + CNT_W'(1);
    bit_n      = bit_idx;
    mask_n     = mask;
    ch_n       = ch;
    shreg_n    = shreg;
    ss_n_n     = spi_SS_n;
    sclk_n     = spi_SCLK;
    mosi_n     = spi_MOSI;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    busy_n     = busy;
    res_ch_n   = res_ch;
    res_data_n = res_data;
    start      = 1'b0;
    sample     = 1'b0;
`ifdef SPI_ADC_SCAN_OVERSAMPLE_EN
    os_cnt_n   = os_cnt;
    acc_n      = acc;
`endif
    case (state)
      IDLE: if (go_edge) begin
        if (first_hit[CH_W]) begin
          mask_n = ch_en;
          ch_n   = first_hit[CH_W-1:0];
          start  = 1'b1;
        end else begin
          done_n = 1'b1;
        end
      end
      SETUP, LOW: if (tick) begin
        state_n = HIGH;
        sclk_n  = 1'b1;
        sample  = 1'b1;
      end
      HIGH: if (tick) begin
        sclk_n = 1'b0;
        if (bit_idx == 4'd15) begin
          state_n = HOLD;
          mosi_n  = 1'b0;
        end else begin
          state_n = LOW;
          bit_n   = bit_idx + 4'd1;
          mosi_n  = tx_word[4'd15 - bit_n];
        end
      end
      HOLD: if (tick) begin
        state_n = GAP;
        ss_n_n  = 1'b1;
`ifdef SPI_ADC_SCAN_OVERSAMPLE_EN
        os_cnt_n = os_cnt + 2'd1;
        if (os_cnt == 2'd3) begin
          valid_n    = 1'b1;
          res_ch_n   = ch;
          res_data_n = acc_sum[DATA_W+1:2];
          acc_n      = '0;
          done_n     = !next_hit[CH_W];
        end else begin
          acc_n = acc_sum;
        end
`else
        valid_n    = 1'b1;
        res_ch_n   = ch;
        res_data_n = shreg;
        done_n     = !next_hit[CH_W];
`endif
      end
      GAP: if (tick) begin
        if (more) begin
          start = 1'b1;
        end else if (next_hit[CH_W]) begin
          ch_n  = next_hit[CH_W-1:0];
          start = 1'b1;
        end else if (cont && first_hit[CH_W]) begin
          mask_n = ch_en;
          ch_n   = first_hit[CH_W-1:0];
          start  = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // Only the last DATA_W rising edges carry conversion bits
    if (sample && bit_idx >= 4'(DSKIP))
      shreg_n = (shreg << 1) | DATA_W'(spi_MISO);
    if (start) begin
      state_n = SETUP;
      ss_n_n  = 1'b0;
      sclk_n  = 1'b0;
      mosi_n  = 1'b1;
      bit_n   = 4'd0;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      mask      <= '0;
      ch        <= '0;
      shreg     <= '0;
      go_q      <= 1'b0;
      go_edge   <= 1'b0;
      spi_SS_n  <= 1'b1;
      spi_SCLK  <= 1'b0;
      spi_MOSI  <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
`ifdef SPI_ADC_SCAN_OVERSAMPLE_EN
      os_cnt    <= '0;
      acc       <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      mask      <= mask_n;
      ch        <= ch_n;
      shreg     <= shreg_n;
      go_q      <= go;
      go_edge   <= go & ~go_q;
      spi_SS_n  <= ss_n_n;
      spi_SCLK  <= sclk_n;
      spi_MOSI  <= mosi_n;
      res_valid <= valid_n;
      res_ch    <= res_ch_n;
      res_data  <= res_data_n;
      busy      <= busy_n;
      scan_done <= done_n;
`ifdef SPI_ADC_SCAN_OVERSAMPLE_EN
      os_cnt    <= os_cnt_n;
      acc       <= acc_n;
`endif
    end
  end
endmodule
